seq_bit_tx: RTL and testbench

Serial bitstream transmitter that drives the `x` input of the `fsmseq` 1011 sequence detector. It accepts a parallel word and a length through a valid/ready load port and shifts the word out MSB-first, one bit per clock. An embedded golden model of the non-overlapping 1011 detector produces `exp_z`, which is cycle-aligned with the detector's `z` output, so benches and on-board checks can compare the two directly.

---
 rtl/fsmseq_pkg.sv | 42 ++++
 rtl/seq_ref_model.sv | 56 +++++
 rtl/seq_bit_tx.sv | 132 +++++++++++++
 tb/tb_seq_bit_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsmseq_pkg.sv
// fsmseq_pkg
// Shared definitions for the 1011 sequence detector family.
//   det_state_t  : detector state encoding S0..S4 (4 bits), identical to the
//                  encoding used by the fsmseq detector so state_out can be
//                  compared directly against the detector's own state.
//   ctrl_state_t : control states of the serial transmitter (IDLE, SHIFT).
//   PATTERN      : the detected sequence, first bit in the MSB.
//   det_next()   : next-state function of the non-overlapping detector.
package fsmseq_pkg;

  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4
  } det_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ctrl_state_t;

  // S4 behaves like S0 on its input: the completing bit is never reused,
  // which is what makes the detector non-overlapping.
  function automatic det_state_t det_next(input det_state_t s, input logic b);
    det_state_t n;
    n = S0;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S3 : S0;
      S3:      n = b ? S4 : S2;
      S4:      n = b ? S1 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_ref_model.sv
// seq_ref_model
// Golden model of the non-overlapping 1011 detector. It consumes x on every
// rising edge, idle cycles included, so its outputs line up cycle for cycle
// with the real detector. Usable standalone as a scoreboard.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   x         in   serial bit seen by the detector
//   exp_z     out  expected detector output (Moore, high while in S4)
//   state_out out  model state, detector encoding
//   match_cnt out  number of entries into S4, saturating at 255
module seq_ref_model
  import fsmseq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic       exp_z,
  output logic [3:0] state_out,
  output logic [7:0] match_cnt
);

  det_state_t state;
  det_state_t state_next;
  logic       enter_match;

  // Next state from the shared transition function.
  always_comb begin
    state_next = det_next(state, x);
  end

  // Only S3 leads into S4, so this fires once per completed pattern.
  assign enter_match = (state_next == S4);

  // Detector state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Match counter, held at its ceiling once it gets there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= 8'd0;
    end else if (enter_match && (match_cnt != 8'hFF)) begin
      match_cnt <= match_cnt + 8'd1;
    end
  end

  assign exp_z     = (state == S4);
  assign state_out = state;

endmodule

// File: rtl/seq_bit_tx.sv
// seq_bit_tx
// Serial transmitter feeding the x input of the fsmseq 1011 detector. A word
// and length are taken through a valid/ready port and shifted out MSB-first
// (bit len-1 first), one bit per clock. An embedded seq_ref_model produces
// the expected detector response.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   load_valid in   a word is offered
//   load_ready out  a word can be accepted this cycle
//   load_data  in   payload, bit len-1 sent first
//   load_len   in   bits to send, 0..WORD_W (larger values clamp to WORD_W)
//   x          out  serial bit, 0 when idle
//   x_valid    out  x carries a payload bit
//   busy       out  transmitter is in SHIFT
//   exp_z      out  expected detector output
//   match_cnt  out  expected match count, saturating
//   state_out  out  golden-model state
module seq_bit_tx
  import fsmseq_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int LEN_W  = $clog2(WORD_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              exp_z,
  output logic [7:0]        match_cnt,
  output logic [3:0]        state_out
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORD_W);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_next;
  logic [LEN_W-1:0]  bits_left;
  logic [LEN_W-1:0]  bits_left_next;

  logic [LEN_W-1:0]  len_clamped;
  logic [WORD_W-1:0] aligned_data;
  logic              last_bit;
  logic              accept;
  logic              start_word;

  // The word is left-aligned on load so the next bit to send is always the
  // register MSB regardless of the length.
  always_comb begin
    len_clamped  = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    aligned_data = load_data << (MAX_LEN - len_clamped);
  end

  assign last_bit   = (state == SHIFT) && (bits_left == ONE);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // A zero-length word is accepted but never starts a transfer.
  assign start_word = accept && (len_clamped != '0);

  // Control state, shift register and bit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bits_left <= bits_left_next;
    end
  end

  // Next-state logic. On the last bit a newly accepted word replaces the
  // register directly so its first bit follows with no gap.
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    bits_left_next = bits_left;
    case (state)
      IDLE: begin
        if (start_word) begin
          state_next     = SHIFT;
          shreg_next     = aligned_data;
          bits_left_next = len_clamped;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (start_word) begin
            shreg_next     = aligned_data;
            bits_left_next = len_clamped;
          end else begin
            state_next     = IDLE;
            shreg_next     = '0;
            bits_left_next = '0;
          end
        end else begin
          shreg_next     = {shreg[WORD_W-2:0], 1'b0};
          bits_left_next = bits_left - ONE;
        end
      end
      default: begin
        state_next     = IDLE;
        shreg_next     = '0;
        bits_left_next = '0;
      end
    endcase
  end

  assign busy    = (state == SHIFT);
  assign x_valid = busy;
  assign x       = busy & shreg[WORD_W-1];

  seq_ref_model u_ref (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .exp_z     (exp_z),
    .state_out (state_out),
    .match_cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_bit_tx.sv
// tb_seq_bit_tx
// Drives seq_bit_tx with directed and random loads. The expected behaviour
// comes from a queue of pending bits (transmitter) and a "bits since last
// match" window (detector), checked every cycle on the falling edge.
module tb_seq_bit_tx;
  import fsmseq_pkg::*;

  localparam int WORD_W = 16;
  localparam int LEN_W  = $clog2(WORD_W) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic [WORD_W-1:0] load_data;
  logic [LEN_W-1:0]  load_len;
  logic              x;
  logic              x_valid;
  logic              busy;
  logic              exp_z;
  logic [7:0]        match_cnt;
  logic [3:0]        state_out;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model state
  bit         txq[$];
  logic [3:0] win;
  int         since;
  bit         zExp;
  int         cntExp;
  int         stExp;
  det_state_t encOf[5] = '{S0, S1, S2, S3, S4};

  // Observation counters for per-test totals
  int xvSeen;
  int zSeen;

  always #5 clk = ~clk;

  seq_bit_tx #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .exp_z      (exp_z),
    .match_cnt  (match_cnt),
    .state_out  (state_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    txq.delete();
    win    = 4'b0000;
    since  = 0;
    zExp   = 1'b0;
    cntExp = 0;
    stExp  = 0;
  endtask

  // A match is the pattern occupying the last four bits, all of which arrived
  // after the previous match. Otherwise the state is the longest pattern
  // prefix that ends the bits seen since the last match.
  task automatic consumeBit(input bit b);
    int w;
    win = {win[2:0], b};
    since++;
    w = int'(win);
    if (since >= 4 && win == 4'b1011) begin
      zExp  = 1'b1;
      since = 0;
      stExp = 4;
      if (cntExp < 255) cntExp++;
    end else begin
      zExp  = 1'b0;
      stExp = 0;
      for (int k = 1; k <= 3; k++) begin
        if (since >= k && ((w & ((1 << k) - 1)) == (11 >> (4 - k)))) stExp = k;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    bit expX;
    expX = (txq.size() > 0) ? txq[0] : 1'b0;
    checkOutput({tag, " x"},          32'(x),          32'(expX));
    checkOutput({tag, " x_valid"},    32'(x_valid),    32'(txq.size() > 0));
    checkOutput({tag, " busy"},       32'(busy),       32'(txq.size() > 0));
    checkOutput({tag, " load_ready"}, 32'(load_ready), 32'(txq.size() <= 1));
    checkOutput({tag, " exp_z"},      32'(exp_z),      32'(zExp));
    checkOutput({tag, " match_cnt"},  32'(match_cnt),  32'(cntExp));
    checkOutput({tag, " state_out"},  32'(state_out),  32'(encOf[stExp]));
  endtask

  // One clock: check outputs, drive the load port, advance the model at the
  // rising edge, and return on the following falling edge.
  task automatic applyStimulus(input bit v, input logic [WORD_W-1:0] d, input logic [LEN_W-1:0] l);
    bit rdy;
    bit b;
    int len;
    checkAll("cycle");
    if (x_valid === 1'b1) xvSeen++;
    if (exp_z === 1'b1) zSeen++;
    load_valid = v;
    load_data  = d;
    load_len   = l;
    rdy = (txq.size() <= 1);
    @(posedge clk);
    b = 1'b0;
    if (txq.size() > 0) b = txq.pop_front();
    consumeBit(b);
    if (v && rdy) begin
      len = (int'(l) > WORD_W) ? WORD_W : int'(l);
      for (int i = len - 1; i >= 0; i--) txq.push_back(d[i]);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom), 5'($urandom_range(0, 31)));
  endtask

  // Called at a falling edge; reset is released well before the next rise.
  task automatic doReset();
    reset = 1'b1;
    resetModel();
    #1 checkAll("reset");
    #1 reset = 1'b0;
    xvSeen = 0;
    zSeen  = 0;
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    doReset();
    @(negedge clk);

    $display("[TB] no match 11001");
    doReset();
    applyStimulus(1'b1, 16'b11001, 5'd5);
    idle(8);
    checkOutput("nomatch xv cycles", 32'(xvSeen), 32'd5);
    checkOutput("nomatch z pulses", 32'(zSeen), 32'd0);
    checkOutput("nomatch cnt", 32'(match_cnt), 32'd0);

    $display("[TB] single match 1011");
    doReset();
    applyStimulus(1'b1, 16'b1011, 5'd4);
    idle(6);
    checkOutput("single z pulses", 32'(zSeen), 32'd1);
    checkOutput("single cnt", 32'(match_cnt), 32'd1);

    $display("[TB] back-to-back 1011 1011");
    doReset();
    applyStimulus(1'b1, 16'b1011, 5'd4);
    idle(3);
    applyStimulus(1'b1, 16'b1011, 5'd4);
    idle(8);
    checkOutput("b2b xv cycles", 32'(xvSeen), 32'd8);
    checkOutput("b2b z pulses", 32'(zSeen), 32'd2);
    checkOutput("b2b cnt", 32'(match_cnt), 32'd2);

    $display("[TB] non-overlap 1011011");
    doReset();
    applyStimulus(1'b1, 16'b1011011, 5'd7);
    idle(10);
    checkOutput("nonovl z pulses", 32'(zSeen), 32'd1);
    checkOutput("nonovl cnt", 32'(match_cnt), 32'd1);

    $display("[TB] zero length");
    doReset();
    applyStimulus(1'b1, 16'hFFFF, 5'd0);
    idle(4);
    checkOutput("len0 xv cycles", 32'(xvSeen), 32'd0);

    $display("[TB] over-length clamp");
    doReset();
    applyStimulus(1'b1, 16'($urandom), 5'(WORD_W + 1));
    idle(20);
    checkOutput("len17 xv cycles", 32'(xvSeen), 32'(WORD_W));

    $display("[TB] reset mid-word");
    doReset();
    applyStimulus(1'b1, 16'hFFFF, 5'd16);
    idle(5);
    checkOutput("midword busy before reset", 32'(busy), 32'd1);
    doReset();
    checkOutput("midword cnt after reset", 32'(match_cnt), 32'd0);
    idle(4);

    $display("[TB] counter saturation");
    doReset();
    for (int w = 0; w < 70; w++) begin
      applyStimulus(1'b1, 16'hBBBB, 5'd16);
      idle(15);
    end
    idle(4);
    checkOutput("sat z pulses", 32'(zSeen), 32'd280);
    checkOutput("sat cnt", 32'(match_cnt), 32'd255);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 5'($urandom_range(0, 31)));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
